sram_access_arbiter: RTL and testbench

- Sequences all external SRAM cycles and shares the single SRAM port between the AVR host and the SNES cartridge bus.
- Generates registered ce_n/oe_n/we_n strobes with configurable wait states.
- Gives the AVR an auto-incrementing address counter, so bulk uploads and dumps need one address load per block instead of one per byte.
- Sits in the CPLD between the AVR interface logic and the SRAM pins.

---
 rtl/sram_arb_pkg.sv | 18 +
 rtl/sram_access_arbiter_if.sv | 58 +++++
 rtl/sram_addr_counter.sv | 39 +++
 rtl/sram_access_arbiter.sv | 126 ++++++++++++
 tb/tb_sram_access_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM access arbiter.
// Holds the FSM state encoding, owner codes and the default bus widths.
package sram_arb_pkg;

  localparam int DEF_ADDR_W = 21;
  localparam int DEF_DATA_W = 8;

  localparam logic OWNER_AVR  = 1'b0;
  localparam logic OWNER_SNES = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } arb_state_t;

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Requester and SRAM pad signals of the arbiter, bundled in one interface.
// The slave modport is the arbiter side; the master modport is everything around it.
interface sram_access_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              avr_req;
  logic              avr_we;
  logic              avr_addr_load;
  logic [ADDR_W-1:0] avr_addr;
  logic [DATA_W-1:0] avr_wdata;
  logic [DATA_W-1:0] avr_rdata;
  logic              avr_ack;

  logic              snes_req;
  logic              snes_we;
  logic [ADDR_W-1:0] snes_addr;
  logic [DATA_W-1:0] snes_wdata;
  logic [DATA_W-1:0] snes_rdata;
  logic              snes_ack;

  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dout;
  logic              sram_dout_en;
  logic [DATA_W-1:0] sram_din;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;

  logic              busy;
  logic              owner;

  modport slave (
    input  avr_req, avr_we, avr_addr_load, avr_addr, avr_wdata,
    output avr_rdata, avr_ack,
    input  snes_req, snes_we, snes_addr, snes_wdata,
    output snes_rdata, snes_ack,
    output sram_addr, sram_dout, sram_dout_en,
    input  sram_din,
    output sram_ce_n, sram_oe_n, sram_we_n,
    output busy, owner
  );

  modport master (
    output avr_req, avr_we, avr_addr_load, avr_addr, avr_wdata,
    input  avr_rdata, avr_ack,
    output snes_req, snes_we, snes_addr, snes_wdata,
    input  snes_rdata, snes_ack,
    input  sram_addr, sram_dout, sram_dout_en,
    output sram_din,
    input  sram_ce_n, sram_oe_n, sram_we_n,
    input  busy, owner
  );

endinterface

// File: rtl/sram_addr_counter.sv
// Auto-incrementing AVR address counter with load priority over increment.
// A load that lands while an AVR access is in flight cancels that access's increment.
module sram_addr_counter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  input  logic              start,
  input  logic              inc,
  output logic [ADDR_W-1:0] count
);

  logic cancel;

  // cancel is re-armed at every AVR grant; a load in the grant cycle already counts as "after grant"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      cancel <= 1'b0;
    end else begin
      if (start) begin
        cancel <= load;
      end else if (load) begin
        cancel <= 1'b1;
      end

      if (load) begin
        count <= load_value;
      end else if (inc && !cancel) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares one external SRAM port between the AVR host and the SNES bus.
// Round-robin arbitration plus a registered IDLE/SETUP/ACCESS/DONE strobe sequencer.
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_access_arbiter_if.slave  bus
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
    $error("sram_access_arbiter: WAIT_CYCLES must be within 1..15");
  end

  arb_state_t        state;
  logic [3:0]        wait_cnt;
  logic              cur_we;
  logic              owner_q;
  logic [ADDR_W-1:0] avr_count;

  logic              grant_avr;
  logic              grant_snes;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // On a tie the requester that did not own the last cycle wins
  always_comb begin
    grant_snes = bus.snes_req && (!bus.avr_req || owner_q == OWNER_AVR);
    grant_avr  = bus.avr_req && !grant_snes;
    sel_we     = grant_snes ? bus.snes_we    : bus.avr_we;
    sel_addr   = grant_snes ? bus.snes_addr  : avr_count;
    sel_wdata  = grant_snes ? bus.snes_wdata : bus.avr_wdata;
  end

  sram_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (bus.avr_addr_load),
    .load_value (bus.avr_addr),
    .start      (state == IDLE && grant_avr),
    .inc        (state == DONE && owner_q == OWNER_AVR),
    .count      (avr_count)
  );

  assign bus.owner = owner_q;

  // Strobes are set one cycle ahead so every pad signal comes straight from a flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      cur_we           <= 1'b0;
      owner_q          <= OWNER_AVR;
      bus.busy         <= 1'b0;
      bus.sram_addr    <= '0;
      bus.sram_dout    <= '0;
      bus.sram_dout_en <= 1'b0;
      bus.sram_ce_n    <= 1'b1;
      bus.sram_oe_n    <= 1'b1;
      bus.sram_we_n    <= 1'b1;
      bus.avr_rdata    <= '0;
      bus.snes_rdata   <= '0;
      bus.avr_ack      <= 1'b0;
      bus.snes_ack     <= 1'b0;
    end else begin
      bus.avr_ack  <= 1'b0;
      bus.snes_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_avr || grant_snes) begin
            state         <= SETUP;
            bus.busy      <= 1'b1;
            owner_q       <= grant_snes ? OWNER_SNES : OWNER_AVR;
            cur_we        <= sel_we;
            bus.sram_addr <= sel_addr;
            bus.sram_ce_n <= 1'b0;
            if (sel_we) begin
              bus.sram_dout    <= sel_wdata;
              bus.sram_dout_en <= 1'b1;
            end else begin
              bus.sram_oe_n <= 1'b0;
            end
          end
        end
        SETUP: begin
          state    <= ACCESS;
          wait_cnt <= 4'(WAIT_CYCLES - 1);
          if (cur_we) begin
            bus.sram_we_n <= 1'b0;
          end
        end
        ACCESS: begin
          if (wait_cnt == '0) begin
            state         <= DONE;
            bus.sram_we_n <= 1'b1;
            bus.sram_oe_n <= 1'b1;
            if (owner_q == OWNER_SNES) begin
              bus.snes_ack <= 1'b1;
              if (!cur_we) bus.snes_rdata <= bus.sram_din;
            end else begin
              bus.avr_ack <= 1'b1;
              if (!cur_we) bus.avr_rdata <= bus.sram_din;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        DONE: begin
          state            <= IDLE;
          bus.busy         <= 1'b0;
          bus.sram_ce_n    <= 1'b1;
          bus.sram_dout_en <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter with WAIT_CYCLES=2.
// Cycle 1 is the cycle right after the granting edge; logs are indexed by that cycle number.
module tb_sram_access_arbiter;
  import sram_arb_pkg::*;

  localparam int ADDR_W      = 21;
  localparam int DATA_W      = 8;
  localparam int WAIT_CYCLES = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [DATA_W-1:0] din_value;

  logic [5:1]  we_log, oe_log, ce_log, en_log, ack_log, busy_log;
  logic [20:0] addr1, addr4;
  logic [7:0]  dout1, rdata4, rdata5;

  logic [15:1] busy_t, idle_t, snes_ack_t, avr_ack_t;
  logic        owner_c1, owner_c6, owner_c11;
  logic [20:0] addr_c1, addr_c6;
  logic [7:0]  snes_rd_c4, avr_rd_c9;

  always #5 clk = ~clk;

  sram_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  assign bus.sram_din = din_value;

  sram_access_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic load_counter(input logic [20:0] value);
    @(negedge clk);
    bus.avr_addr_load = 1'b1;
    bus.avr_addr      = value;
    @(negedge clk);
    bus.avr_addr_load = 1'b0;
  endtask

  // One complete access; optionally pulses avr_addr_load for the edge ending load_cycle
  task automatic apply_stimulus(input bit use_snes, input bit we, input logic [7:0] wdata,
                                input logic [20:0] saddr, input int load_cycle,
                                input logic [20:0] load_val);
    @(negedge clk);
    if (use_snes) begin
      bus.snes_req = 1'b1; bus.snes_we = we; bus.snes_wdata = wdata; bus.snes_addr = saddr;
    end else begin
      bus.avr_req = 1'b1; bus.avr_we = we; bus.avr_wdata = wdata;
    end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.avr_addr_load = 1'b0;
      we_log[c]   = bus.sram_we_n;
      oe_log[c]   = bus.sram_oe_n;
      ce_log[c]   = bus.sram_ce_n;
      en_log[c]   = bus.sram_dout_en;
      busy_log[c] = bus.busy;
      ack_log[c]  = use_snes ? bus.snes_ack : bus.avr_ack;
      if (c == 1) begin
        addr1 = bus.sram_addr;
        dout1 = bus.sram_dout;
      end
      if (c == 4) begin
        addr4  = bus.sram_addr;
        rdata4 = use_snes ? bus.snes_rdata : bus.avr_rdata;
        bus.avr_req  = 1'b0;
        bus.snes_req = 1'b0;
      end
      if (c == 5) rdata5 = use_snes ? bus.snes_rdata : bus.avr_rdata;
      if (c == load_cycle) begin
        bus.avr_addr_load = 1'b1;
        bus.avr_addr      = load_val;
      end
    end
    bus.avr_addr_load = 1'b0;
  endtask

  initial begin
    bus.avr_req = 0; bus.avr_we = 0; bus.avr_addr_load = 0; bus.avr_addr = '0; bus.avr_wdata = '0;
    bus.snes_req = 0; bus.snes_we = 0; bus.snes_addr = '0; bus.snes_wdata = '0;
    din_value = '0;

    #1 rst_n = 1'b0;
    #1;
    check_output("rst_ce_n", 32'(bus.sram_ce_n), 32'h1);
    check_output("rst_oe_n", 32'(bus.sram_oe_n), 32'h1);
    check_output("rst_we_n", 32'(bus.sram_we_n), 32'h1);
    check_output("rst_dout_en", 32'(bus.sram_dout_en), 32'h0);
    check_output("rst_acks", 32'({bus.avr_ack, bus.snes_ack}), 32'h0);
    check_output("rst_rdata", 32'({bus.avr_rdata, bus.snes_rdata}), 32'h0);
    check_output("rst_addr", 32'(bus.sram_addr), 32'h0);
    check_output("rst_busy_owner", 32'({bus.busy, bus.owner}), 32'h0);
    check_output("rst_counter", 32'(dut.u_cnt.count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] AVR write 0xA5 at 0x00010");
    load_counter(21'h00010);
    apply_stimulus(1'b0, 1'b1, 8'hA5, '0, 0, '0);
    check_output("wr_we_n", 32'(we_log), 32'(5'b11001));
    check_output("wr_oe_n", 32'(oe_log), 32'(5'b11111));
    check_output("wr_ce_n", 32'(ce_log), 32'(5'b10000));
    check_output("wr_dout_en", 32'(en_log), 32'(5'b01111));
    check_output("wr_ack", 32'(ack_log), 32'(5'b01000));
    check_output("wr_busy", 32'(busy_log), 32'(5'b01111));
    check_output("wr_addr", 32'(addr1), 32'h00010);
    check_output("wr_dout", 32'(dout1), 32'hA5);
    check_output("wr_counter", 32'(dut.u_cnt.count), 32'h00011);

    $display("[TB] AVR read, SRAM returns 0x5A");
    din_value = 8'h5A;
    apply_stimulus(1'b0, 1'b0, 8'h00, '0, 0, '0);
    check_output("rd_oe_n", 32'(oe_log), 32'(5'b11000));
    check_output("rd_we_n", 32'(we_log), 32'(5'b11111));
    check_output("rd_dout_en", 32'(en_log), 32'(5'b00000));
    check_output("rd_ack", 32'(ack_log), 32'(5'b01000));
    check_output("rd_addr", 32'(addr1), 32'h00011);
    check_output("rd_rdata_ack", 32'(rdata4), 32'h5A);
    check_output("rd_rdata_hold", 32'(rdata5), 32'h5A);
    check_output("rd_counter", 32'(dut.u_cnt.count), 32'h00012);

    $display("[TB] both requesters high at reset release");
    @(negedge clk);
    rst_n = 1'b0;
    din_value = 8'h3C;
    bus.avr_req = 1'b1; bus.avr_we = 1'b0;
    bus.snes_req = 1'b1; bus.snes_we = 1'b0; bus.snes_addr = 21'h01234;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      busy_t[c]     = bus.busy;
      idle_t[c]     = bus.sram_ce_n & bus.sram_oe_n & bus.sram_we_n & ~bus.sram_dout_en;
      snes_ack_t[c] = bus.snes_ack;
      avr_ack_t[c]  = bus.avr_ack;
      if (c == 1)  begin owner_c1 = bus.owner; addr_c1 = bus.sram_addr; end
      if (c == 4)  snes_rd_c4 = bus.snes_rdata;
      if (c == 6)  begin owner_c6 = bus.owner; addr_c6 = bus.sram_addr; end
      if (c == 9)  avr_rd_c9 = bus.avr_rdata;
      if (c == 11) owner_c11 = bus.owner;
      if (c == 15) begin bus.avr_req = 1'b0; bus.snes_req = 1'b0; end
    end
    check_output("rr_busy", 32'(busy_t), 32'(15'b011110111101111));
    check_output("rr_idle_strobes", 32'(idle_t), 32'(15'b100001000010000));
    check_output("rr_snes_ack", 32'(snes_ack_t), 32'(15'b010000000001000));
    check_output("rr_avr_ack", 32'(avr_ack_t), 32'(15'b000000100000000));
    check_output("rr_owner1", 32'(owner_c1), 32'(OWNER_SNES));
    check_output("rr_owner2", 32'(owner_c6), 32'(OWNER_AVR));
    check_output("rr_owner3", 32'(owner_c11), 32'(OWNER_SNES));
    check_output("rr_snes_addr", 32'(addr_c1), 32'h01234);
    check_output("rr_avr_addr", 32'(addr_c6), 32'h00000);
    check_output("rr_snes_rdata", 32'(snes_rd_c4), 32'h3C);
    check_output("rr_avr_rdata", 32'(avr_rd_c9), 32'h3C);
    check_output("rr_counter", 32'(dut.u_cnt.count), 32'h00001);

    $display("[TB] AVR read at top of address space");
    din_value = 8'h81;
    load_counter(21'h1FFFFF);
    apply_stimulus(1'b0, 1'b0, 8'h00, '0, 0, '0);
    check_output("wrap_addr", 32'(addr1), 32'h1FFFFF);
    check_output("wrap_rdata", 32'(rdata4), 32'h81);
    check_output("wrap_counter", 32'(dut.u_cnt.count), 32'h000000);

    $display("[TB] counter load during an in-flight AVR write");
    load_counter(21'h00050);
    apply_stimulus(1'b0, 1'b1, 8'h66, '0, 2, 21'h00100);
    check_output("ld_addr_setup", 32'(addr1), 32'h00050);
    check_output("ld_addr_done", 32'(addr4), 32'h00050);
    check_output("ld_dout", 32'(dout1), 32'h66);
    check_output("ld_we_n", 32'(we_log), 32'(5'b11001));
    check_output("ld_ack", 32'(ack_log), 32'(5'b01000));
    check_output("ld_counter", 32'(dut.u_cnt.count), 32'h00100);

    $display("[TB] SNES write leaves AVR counter alone");
    apply_stimulus(1'b1, 1'b1, 8'hC3, 21'h0ABCD, 0, '0);
    check_output("snes_wr_addr", 32'(addr1), 32'h0ABCD);
    check_output("snes_wr_dout", 32'(dout1), 32'hC3);
    check_output("snes_wr_we_n", 32'(we_log), 32'(5'b11001));
    check_output("snes_wr_ack", 32'(ack_log), 32'(5'b01000));
    check_output("snes_wr_owner", 32'(bus.owner), 32'(OWNER_SNES));
    check_output("snes_wr_counter", 32'(dut.u_cnt.count), 32'h00100);

    $display("[TB] reset asserted mid-ACCESS of an AVR write");
    @(negedge clk);
    bus.avr_req = 1'b1; bus.avr_we = 1'b1; bus.avr_wdata = 8'h77;
    @(negedge clk);
    @(negedge clk);
    check_output("mid_we_low", 32'(bus.sram_we_n), 32'h0);
    #1 rst_n = 1'b0;
    #1;
    check_output("mid_we_n", 32'(bus.sram_we_n), 32'h1);
    check_output("mid_ce_n", 32'(bus.sram_ce_n), 32'h1);
    check_output("mid_dout_en", 32'(bus.sram_dout_en), 32'h0);
    check_output("mid_busy", 32'(bus.busy), 32'h0);
    bus.avr_req = 1'b0;
    @(negedge clk);
    check_output("mid_ack", 32'({bus.avr_ack, bus.snes_ack}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_output("mid_state", 32'(dut.state), 32'(IDLE));
    check_output("mid_post_ack", 32'({bus.avr_ack, bus.snes_ack}), 32'h0);
    check_output("mid_post_ce_n", 32'(bus.sram_ce_n), 32'h1);
    check_output("mid_counter", 32'(dut.u_cnt.count), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
